// File: rtl/pingpong_drain_pkg.sv
// Shared flash-controller constants: drain FSM encoding and default geometry.
package pingpong_drain_pkg;

  localparam int DRAIN_DATA_W     = 8;
  localparam int DRAIN_ADDR_W     = 11;
  localparam int DRAIN_PAGE_WORDS = 2048;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } drain_state_e;

endpackage

// File: rtl/pingpong_drain.sv
// Drains the bank just released by the writer, one word per 3 cycles,
// through a valid/ready port towards the flash write path.
module pingpong_drain
  import pingpong_drain_pkg::*;
#(
  parameter int DATA_W     = DRAIN_DATA_W,
  parameter int ADDR_W     = DRAIN_ADDR_W,
  parameter int PAGE_WORDS = DRAIN_PAGE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_change,
  input  logic              ram_adj,
  output logic              ram_busy,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              drain_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_WORDS - 1);

  drain_state_e      state_reg, state_next;
  logic              rd_bank_reg, rd_bank_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              overrun_reg, overrun_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rd_bank_reg <= 1'b0;
      rd_addr_reg <= '0;
      dout_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_bank_reg <= rd_bank_next;
      rd_addr_reg <= rd_addr_next;
      dout_reg    <= dout_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    rd_addr_next = rd_addr_reg;
    dout_next    = dout_reg;
    // A bank switch outside IDLE (DONE included) is flagged and otherwise dropped.
    overrun_next = overrun_reg | (ram_change && (state_reg != ST_IDLE));
    case (state_reg)
      ST_IDLE: begin
        if (ram_change) begin
          rd_bank_next = ~ram_adj;
          rd_addr_next = '0;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LOAD;
      ST_LOAD: begin
        dout_next  = rd_data;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (dout_ready) begin
          if (rd_addr_reg == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            rd_addr_next = rd_addr_reg + ADDR_W'(1);
            state_next   = ST_FETCH;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign ram_busy   = (state_reg != ST_IDLE);
  assign rd_en      = (state_reg == ST_FETCH);
  assign dout_valid = (state_reg == ST_SEND);
  assign drain_done = (state_reg == ST_DONE);
  assign rd_bank    = rd_bank_reg;
  assign rd_addr    = rd_addr_reg;
  assign dout       = dout_reg;
  assign overrun    = overrun_reg;

endmodule
